// File: rtl/ram8_dump_reader_if.sv
// Bundle of the write/random-read port and the dump stream of ram8_dump_reader.
// Stream rule: a word transfers on a rising edge where dout_valid && dout_ready.
interface ram8_dump_reader_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic [AW-1:0]    address;
  logic [WIDTH-1:0] out;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] dout;
  logic [AW-1:0]    dout_addr;
  logic             dout_valid;
  logic             dout_ready;
  logic             done;
  logic [1:0]       dbg_state;

  modport master (
    output in, load, address, start, dout_ready,
    input  out, busy, dout, dout_addr, dout_valid, done, dbg_state
  );

  modport slave (
    input  in, load, address, start, dout_ready,
    output out, busy, dout, dout_addr, dout_valid, done, dbg_state
  );
endinterface

// File: rtl/ram8_dump_reader.sv
// Register bank with a combinational random-read port and a sequencer that
// streams every word, address 0..DEPTH-1, over a valid/ready interface.
module ram8_dump_reader #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  ram8_dump_reader_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_addr_q;
  logic [WIDTH-1:0] dout_q;
  logic [AW-1:0]    dout_addr_q;
  logic             dout_valid_q;
  logic             handshake;
  logic             last_word;
  logic             busy_c;
  logic             done_c;

  assign handshake = dout_valid_q && bus.dout_ready;
  assign last_word = (rd_addr_q == AW'(DEPTH - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_SEND;
      ST_SEND:  if (handshake) state_d = last_word ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state_q)
      ST_FETCH, ST_SEND: busy_c = 1'b1;
      ST_DONE:           done_c = 1'b1;
      default:           ;
    endcase
  end

  // Writes are accepted in every state; a fetch on the same edge sees the old word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (bus.load) begin
      mem_q[bus.address] <= bus.in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q    <= '0;
      dout_q       <= '0;
      dout_addr_q  <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) rd_addr_q <= '0;
        end
        ST_FETCH: begin
          dout_q       <= mem_q[rd_addr_q];
          dout_addr_q  <= rd_addr_q;
          dout_valid_q <= 1'b1;
        end
        ST_SEND: begin
          if (handshake) begin
            dout_valid_q <= 1'b0;
            if (!last_word) rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out        = mem_q[bus.address];
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.dout       = dout_q;
  assign bus.dout_addr  = dout_addr_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_ram8_dump_reader.sv
// Self-checking bench for ram8_dump_reader: directed dump scenarios plus
// randomized fills and back-pressure against a word-array reference model.
module tb_ram8_dump_reader;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  ram8_dump_reader_if #(.WIDTH(16), .AW(3)) bus ();

  ram8_dump_reader #(.WIDTH(16), .DEPTH(8), .AW(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests_run = 0;
  int fails     = 0;

  logic [15:0] model_mem [8];
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];
  logic [2:0]  got_addr_q [$];
  int          done_at_q [$];
  int          first_valid_n;
  int          stall_err = 0;

  // Monitor: records accepted words and checks the word holds while stalled.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_dout;
  logic [2:0]  prev_addr;
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus.dout_valid || bus.dout !== prev_dout || bus.dout_addr !== prev_addr))
        stall_err++;
      if (bus.dout_valid && bus.dout_ready) begin
        got_q.push_back(bus.dout);
        got_addr_q.push_back(bus.dout_addr);
      end
      prev_stall = bus.dout_valid && !bus.dout_ready;
      prev_dout  = bus.dout;
      prev_addr  = bus.dout_addr;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [2:0] a, input logic [15:0] d);
    bus.load    = 1'b1;
    bus.address = a;
    bus.in      = d;
    tick();
    bus.load    = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic fill_tens();
    for (int i = 0; i < 8; i++) write_word(3'(i), 16'(10 * (i + 1)));
  endtask

  // ready_mode: 0 always ready, 1 toggles every 3 cycles, 2 random.
  // start_hold: start driven for this many edges from the start edge; <0 = held.
  // reset_at: cycle after the start edge at which reset_n drops (0 = never).
  task automatic run_dump(input int ready_mode, input bit hazard, input int start_hold,
                          input int reset_at, input int budget);
    got_q.delete();
    got_addr_q.delete();
    done_at_q.delete();
    stall_err     = 0;
    first_valid_n = -1;
    bus.dout_ready = (ready_mode == 0);
    bus.start = 1'b1;
    tick();
    for (int n = 0; n <= budget; n++) begin
      if (n > 0) begin
        if (bus.done) done_at_q.push_back(n);
        if (bus.dout_valid && first_valid_n < 0) first_valid_n = n;
      end
      if (reset_at != 0 && n == reset_at) begin
        reset_n = 1'b0;
        break;
      end
      bus.start = (start_hold < 0) ? 1'b1 : (n + 1 < start_hold);
      case (ready_mode)
        0:       bus.dout_ready = 1'b1;
        1:       bus.dout_ready = ((n / 3) % 2) == 1;
        default: bus.dout_ready = 1'($urandom_range(0, 1));
      endcase
      bus.load = 1'b0;
      if (hazard) begin
        if (n == 1) begin bus.load = 1'b1; bus.address = 3'd5; bus.in = 16'd555; model_mem[5] = 16'd555; end
        if (n == 4) begin bus.load = 1'b1; bus.address = 3'd1; bus.in = 16'd111; model_mem[1] = 16'd111; end
        if (n == 6) begin bus.load = 1'b1; bus.address = 3'd3; bus.in = 16'd333; model_mem[3] = 16'd333; end
      end
      tick();
    end
    bus.start = 1'b0;
    bus.load  = 1'b0;
    if (reset_n) begin
      bus.dout_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
        if (!bus.busy && !bus.done) break;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.load = 1'b0; bus.start = 1'b0; bus.dout_ready = 1'b0;
    bus.in = '0; bus.address = '0;
    for (int i = 0; i < 8; i++) model_mem[i] = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (bus.dout_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: valid=%b done=%b busy=%b, required 0 0 0", bus.dout_valid, bus.done, bus.busy);
    end
    tests_run++;
    if (bus.dout !== 16'd0 || bus.dout_addr !== 3'd0) begin
      fails++;
      $display("FAIL reset_dout: dout=%0d addr=%0d, required 0 0", bus.dout, bus.dout_addr);
    end
    for (int i = 0; i < 8; i++) begin
      bus.address = 3'(i);
      #1;
      tests_run++;
      if (bus.out !== 16'd0) begin
        fails++;
        $display("FAIL reset_out[%0d]: got %0d, required 0", i, bus.out);
      end
    end
  endtask

  task automatic test_write_read();
    fill_tens();
    for (int i = 0; i < 8; i++) begin
      bus.address = 3'(i);
      #1;
      tests_run++;
      if (bus.out !== model_mem[i]) begin
        fails++;
        $display("FAIL write_read[%0d]: got %0d, required %0d", i, bus.out, model_mem[i]);
      end
    end
  endtask

  task automatic test_dump_ready();
    fill_tens();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(model_mem[i]);
    run_dump(0, 1'b0, 1, 0, 24);
    tests_run++;
    if (first_valid_n !== 1) begin
      fails++;
      $display("FAIL dump_latency: first valid after %0d edges, required 1", first_valid_n);
    end
    tests_run++;
    if (done_at_q.size() != 1 || done_at_q[0] != 16) begin
      fails++;
      $display("FAIL dump_done: %0d done pulses, first at %0d, required one at 16",
               done_at_q.size(), (done_at_q.size() > 0) ? done_at_q[0] : -1);
    end
    tests_run++;
    if (got_q.size() != 8) begin
      fails++;
      $display("FAIL dump_count: got %0d words, required 8", got_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        tests_run++;
        if (got_q[k] !== exp_q[k] || got_addr_q[k] !== 3'(k)) begin
          fails++;
          $display("FAIL dump_word[%0d]: got %0d@%0d, required %0d@%0d", k, got_q[k], got_addr_q[k], exp_q[k], k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    fill_tens();
    run_dump(1, 1'b0, 1, 0, 60);
    tests_run++;
    if (stall_err != 0 || done_at_q.size() != 1) begin
      fails++;
      $display("FAIL bp_stall: unstable=%0d dones=%0d, required 0 and 1", stall_err, done_at_q.size());
    end
    tests_run++;
    if (got_q.size() != 8) begin
      fails++;
      $display("FAIL bp_count: got %0d words, required 8", got_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        tests_run++;
        if (got_q[k] !== 16'(10 * (k + 1)) || got_addr_q[k] !== 3'(k)) begin
          fails++;
          $display("FAIL bp_word[%0d]: got %0d@%0d, required %0d@%0d", k, got_q[k], got_addr_q[k], 10 * (k + 1), k);
        end
      end
    end
  endtask

  task automatic test_hazard();
    fill_tens();
    exp_q = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd555, 16'd70, 16'd80};
    run_dump(0, 1'b1, 1, 0, 24);
    tests_run++;
    if (got_q.size() != 8) begin
      fails++;
      $display("FAIL hazard_count: got %0d words, required 8", got_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        tests_run++;
        if (got_q[k] !== exp_q[k]) begin
          fails++;
          $display("FAIL hazard_word[%0d]: got %0d, required %0d", k, got_q[k], exp_q[k]);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      bus.address = 3'(i);
      #1;
      tests_run++;
      if (bus.out !== model_mem[i]) begin
        fails++;
        $display("FAIL hazard_mem[%0d]: got %0d, required %0d", i, bus.out, model_mem[i]);
      end
    end
  endtask

  task automatic test_start_busy();
    fill_tens();
    run_dump(0, 1'b0, 10, 0, 30);
    tests_run++;
    if (done_at_q.size() != 1 || got_q.size() != 8) begin
      fails++;
      $display("FAIL start_busy: dones=%0d words=%0d, required 1 and 8", done_at_q.size(), got_q.size());
    end
    // Held start: second dump starts from the IDLE cycle after DONE.
    run_dump(0, 1'b0, -1, 0, 34);
    tests_run++;
    if (done_at_q.size() != 2 || done_at_q[0] != 16 || done_at_q[1] != 34) begin
      fails++;
      $display("FAIL start_held: %0d dones at %0d,%0d, required 2 at 16,34", done_at_q.size(),
               (done_at_q.size() > 0) ? done_at_q[0] : -1, (done_at_q.size() > 1) ? done_at_q[1] : -1);
    end
    tests_run++;
    if (got_q.size() != 16) begin
      fails++;
      $display("FAIL start_held_words: got %0d words, required 16", got_q.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        tests_run++;
        if (got_q[k] !== model_mem[k % 8] || got_addr_q[k] !== 3'(k % 8)) begin
          fails++;
          $display("FAIL start_held_word[%0d]: got %0d@%0d, required %0d@%0d", k, got_q[k], got_addr_q[k], model_mem[k % 8], k % 8);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones_seen;
    fill_tens();
    run_dump(0, 1'b0, 1, 7, 40);
    #1;
    tests_run++;
    if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dout !== 16'd0) begin
      fails++;
      $display("FAIL midreset_out: valid=%b busy=%b dout=%0d, required 0 0 0", bus.dout_valid, bus.busy, bus.dout);
    end
    tests_run++;
    if (got_q.size() != 3 || done_at_q.size() != 0) begin
      fails++;
      $display("FAIL midreset_words: words=%0d dones=%0d, required 3 and 0", got_q.size(), done_at_q.size());
    end
    dones_seen = 0;
    repeat (2) begin
      @(negedge clock);
      if (bus.done) dones_seen++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) model_mem[i] = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done) dones_seen++;
    end
    tests_run++;
    if (dones_seen != 0) begin
      fails++;
      $display("FAIL midreset_done: %0d done cycles, required 0", dones_seen);
    end
    for (int i = 0; i < 8; i++) begin
      bus.address = 3'(i);
      #1;
      tests_run++;
      if (bus.out !== 16'd0) begin
        fails++;
        $display("FAIL midreset_mem[%0d]: got %0d, required 0", i, bus.out);
      end
    end
    run_dump(0, 1'b0, 1, 0, 24);
    tests_run++;
    if (got_q.size() != 8 || done_at_q.size() != 1) begin
      fails++;
      $display("FAIL midreset_redump: words=%0d dones=%0d, required 8 and 1", got_q.size(), done_at_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        tests_run++;
        if (got_q[k] !== 16'd0 || got_addr_q[k] !== 3'(k)) begin
          fails++;
          $display("FAIL midreset_word[%0d]: got %0d@%0d, required 0@%0d", k, got_q[k], got_addr_q[k], k);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 8; i++) write_word(3'(i), 16'($urandom_range(0, 16'hffff)));
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(model_mem[i]);
      run_dump(2, 1'b0, 1, 0, 90);
      tests_run++;
      if (got_q.size() != 8 || done_at_q.size() != 1 || stall_err != 0) begin
        fails++;
        $display("FAIL rand%0d_shape: words=%0d dones=%0d unstable=%0d, required 8 1 0",
                 it, got_q.size(), done_at_q.size(), stall_err);
      end else begin
        for (int k = 0; k < 8; k++) begin
          tests_run++;
          if (got_q[k] !== exp_q[k] || got_addr_q[k] !== 3'(k)) begin
            fails++;
            $display("FAIL rand%0d_word[%0d]: got %0h@%0d, required %0h@%0d", it, k, got_q[k], got_addr_q[k], exp_q[k], k);
          end
        end
      end
      bus.address = 3'($urandom_range(0, 7));
      #1;
      tests_run++;
      if (bus.out !== model_mem[bus.address]) begin
        fails++;
        $display("FAIL rand%0d_read: got %0h, required %0h", it, bus.out, model_mem[bus.address]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_dump_ready();
    test_backpressure();
    test_hazard();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
